// File: rtl/chacha20_keystream_sequencer.sv
// Avalon-MM master that sequences a ChaCha20 CSR core into a valid/ready stream of keystream words.
// Optional build macro CHACHA_SEQ_WRAP_GUARD_EN: end the run instead of letting the block counter wrap.
module chacha20_keystream_sequencer #(
    parameter int DOUBLE_ROUNDS = 10,
    parameter int BLK_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_i,
    input  logic [255:0]     key_i,
    input  logic [95:0]      nonce_i,
    input  logic [31:0]      counter_i,
    input  logic [BLK_W-1:0] num_blocks_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic             m_read,
    output logic             m_write,
    output logic [5:0]       m_address,
    output logic [31:0]      m_writedata,
    input  logic [31:0]      m_readdata,
    output logic [31:0]      ks_data_o,
    output logic             ks_valid_o,
    input  logic             ks_ready_i,
    output logic             ks_last_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_POLL_REQ, S_POLL_WAIT, S_READ_REQ, S_READ_WAIT, S_OUT
    } state_t;

    localparam logic [BLK_W-1:0] ONE_BLK   = {{(BLK_W-1){1'b0}}, 1'b1};
    localparam logic [BLK_W-1:0] ZERO_BLK  = {BLK_W{1'b0}};
    localparam logic [31:0]      CTRL_WORD = 32'(DOUBLE_ROUNDS);

    state_t            state_r, state_s;
    logic [255:0]      key_r, key_s;
    logic [95:0]       nonce_r, nonce_s;
    logic [31:0]       counter_r, counter_s;
    logic [BLK_W-1:0]  blocks_left_r, blocks_left_s;
    logic [3:0]        word_r, word_s;
    logic              first_r, first_s;
    logic              busy_r, busy_s, done_r, done_s, error_r, error_s;
    logic [31:0]       ks_data_r, ks_data_s;
    logic              ks_valid_r, ks_valid_s, ks_last_r, ks_last_s;
    logic              m_read_r, m_read_s, m_write_r, m_write_s;
    logic [5:0]        m_address_r, m_address_s;
    logic [31:0]       m_writedata_r, m_writedata_s;
    logic              wrap_stop_s;

    // ChaCha20 initial state word idx built from the latched key/nonce/counter
    function automatic logic [31:0] init_word(input logic [3:0] idx, input logic [255:0] key,
                                              input logic [95:0] nonce, input logic [31:0] ctr);
        logic [31:0] w;
        logic [2:0]  k;
        k = 3'(idx - 4'd4);
        case (idx)
            4'd0:    w = 32'h61707865;
            4'd1:    w = 32'h3320646e;
            4'd2:    w = 32'h79622d32;
            4'd3:    w = 32'h6b206574;
            4'd12:   w = ctr;
            4'd13:   w = nonce[31:0];
            4'd14:   w = nonce[63:32];
            4'd15:   w = nonce[95:64];
            default: w = key[{k, 5'd0} +: 32];
        endcase
        return w;
    endfunction

`ifdef CHACHA_SEQ_WRAP_GUARD_EN
    assign wrap_stop_s = (counter_r == 32'hFFFF_FFFF);
`else
    assign wrap_stop_s = 1'b0;
`endif

    // Next-state and datapath updates
    always_comb begin
        state_s       = state_r;
        key_s         = key_r;
        nonce_s       = nonce_r;
        counter_s     = counter_r;
        blocks_left_s = blocks_left_r;
        word_s        = word_r;
        first_s       = first_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        error_s       = error_r;
        ks_data_s     = ks_data_r;
        ks_valid_s    = ks_valid_r;
        ks_last_s     = ks_last_r;
        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    error_s = 1'b0;
                    if (num_blocks_i == ZERO_BLK) begin
                        done_s = 1'b1;
                    end else begin
                        key_s         = key_i;
                        nonce_s       = nonce_i;
                        counter_s     = counter_i;
                        blocks_left_s = num_blocks_i;
                        word_s        = 4'd0;
                        first_s       = 1'b1;
                        busy_s        = 1'b1;
                        state_s       = S_LOAD;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                // later blocks only rewrite the counter word, so they leave after one write
                if (first_r && (word_r != 4'd15)) begin
                    word_s = word_r + 4'd1;
                end else begin
                    state_s = S_START;
                end
            end
            S_START:     state_s = S_POLL_REQ;
            S_POLL_REQ:  state_s = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (m_readdata[3:0] == 4'd0) begin
                    word_s  = 4'd0;
                    state_s = S_READ_REQ;
                end else begin
                    state_s = S_POLL_REQ;
                end
            end
            S_READ_REQ:  state_s = S_READ_WAIT;
            S_READ_WAIT: begin
                ks_data_s  = m_readdata;
                ks_valid_s = 1'b1;
                ks_last_s  = (word_r == 4'd15) && ((blocks_left_r == ONE_BLK) || wrap_stop_s);
                state_s    = S_OUT;
            end
            S_OUT: begin
                if (ks_ready_i) begin
                    ks_valid_s = 1'b0;
                    ks_last_s  = 1'b0;
                    if (word_r != 4'd15) begin
                        word_s  = word_r + 4'd1;
                        state_s = S_READ_REQ;
                    end else begin
                        blocks_left_s = blocks_left_r - ONE_BLK;
                        counter_s     = counter_r + 32'd1;
                        if (blocks_left_r == ONE_BLK) begin
                            done_s  = 1'b1;
                            busy_s  = 1'b0;
                            state_s = S_IDLE;
                        end else if (wrap_stop_s) begin
                            error_s = 1'b1;
                            done_s  = 1'b1;
                            busy_s  = 1'b0;
                            state_s = S_IDLE;
                        end else begin
                            word_s  = 4'd12;
                            first_s = 1'b0;
                            state_s = S_LOAD;
                        end
                    end
                end else begin
                    state_s = S_OUT;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Bus command for the state being entered, so the registered strobes line up with it
    always_comb begin
        m_read_s      = 1'b0;
        m_write_s     = 1'b0;
        m_address_s   = 6'd0;
        m_writedata_s = 32'd0;
        case (state_s)
            S_LOAD: begin
                m_write_s     = 1'b1;
                m_address_s   = {2'b00, word_s};
                m_writedata_s = init_word(word_s, key_s, nonce_s, counter_s);
            end
            S_START: begin
                m_write_s     = 1'b1;
                m_address_s   = 6'h20;
                m_writedata_s = CTRL_WORD;
            end
            S_POLL_REQ: begin
                m_read_s    = 1'b1;
                m_address_s = 6'h20;
            end
            S_READ_REQ: begin
                m_read_s    = 1'b1;
                m_address_s = {2'b01, word_s};
            end
            default: begin
                m_read_s  = 1'b0;
                m_write_s = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= S_IDLE;
            key_r         <= 256'd0;
            nonce_r       <= 96'd0;
            counter_r     <= 32'd0;
            blocks_left_r <= ZERO_BLK;
            word_r        <= 4'd0;
            first_r       <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            error_r       <= 1'b0;
            ks_data_r     <= 32'd0;
            ks_valid_r    <= 1'b0;
            ks_last_r     <= 1'b0;
            m_read_r      <= 1'b0;
            m_write_r     <= 1'b0;
            m_address_r   <= 6'd0;
            m_writedata_r <= 32'd0;
        end else begin
            state_r       <= state_s;
            key_r         <= key_s;
            nonce_r       <= nonce_s;
            counter_r     <= counter_s;
            blocks_left_r <= blocks_left_s;
            word_r        <= word_s;
            first_r       <= first_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            error_r       <= error_s;
            ks_data_r     <= ks_data_s;
            ks_valid_r    <= ks_valid_s;
            ks_last_r     <= ks_last_s;
            m_read_r      <= m_read_s;
            m_write_r     <= m_write_s;
            m_address_r   <= m_address_s;
            m_writedata_r <= m_writedata_s;
        end
    end

    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign error_o     = error_r;
    assign ks_data_o   = ks_data_r;
    assign ks_valid_o  = ks_valid_r;
    assign ks_last_o   = ks_last_r;
    assign m_read      = m_read_r;
    assign m_write     = m_write_r;
    assign m_address   = m_address_r;
    assign m_writedata = m_writedata_r;

endmodule

// File: tb/tb_chacha20_keystream_sequencer.sv
// Bench for chacha20_keystream_sequencer: behavioural ChaCha20 CSR core plus a block-level reference model.
module tb_chacha20_keystream_sequencer;
    localparam int DR    = 10;
    localparam int BLK_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             start_i;
    logic [255:0]     key_i;
    logic [95:0]      nonce_i;
    logic [31:0]      counter_i;
    logic [BLK_W-1:0] num_blocks_i;
    logic             busy_o, done_o, error_o;
    logic             m_read, m_write;
    logic [5:0]       m_address;
    logic [31:0]      m_writedata;
    logic [31:0]      m_readdata = 32'd0;
    logic [31:0]      ks_data_o;
    logic             ks_valid_o, ks_last_o;
    logic             ks_ready_i;

    chacha20_keystream_sequencer #(.DOUBLE_ROUNDS(DR), .BLK_W(BLK_W)) dut (
        .clock(clock), .reset(reset), .start_i(start_i), .key_i(key_i), .nonce_i(nonce_i),
        .counter_i(counter_i), .num_blocks_i(num_blocks_i), .busy_o(busy_o), .done_o(done_o),
        .error_o(error_o), .m_read(m_read), .m_write(m_write), .m_address(m_address),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .ks_data_o(ks_data_o),
        .ks_valid_o(ks_valid_o), .ks_ready_i(ks_ready_i), .ks_last_o(ks_last_o)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] got_q[$];
    bit          last_q[$];
    logic [31:0] exp_q[$];
    int          done_cnt = 0, wr_cnt = 0, rd_cnt = 0;
    bit          bp_mode = 1'b0, core_jitter = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data;
    bit          prev_last;
    int          gap = 0;

    logic [31:0] rfc [16] = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                              32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                              32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                              32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] block_fn(input logic [511:0] st, input int dr);
        logic [31:0]  x [16];
        logic [511:0] r;
        for (int i = 0; i < 16; i++) x[i] = st[i*32 +: 32];
        for (int d = 0; d < dr; d++) begin
            {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
            {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
            {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
            {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
            {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
            {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
            {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
            {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
        end
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = x[i] + st[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                               input logic [31:0] c);
        return block_fn({n, c, k, 32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865}, DR);
    endfunction

    // Behavioural CSR core: final state computed at the CONTROL write, exposed once the countdown ends
    logic [511:0] init_p = 512'd0, final_p = 512'd0;
    logic [3:0]   ctrl = 4'd0;
    always @(posedge clock) begin
        if (m_write) begin
            if (m_address[5:4] == 2'b00) init_p[int'(m_address[3:0])*32 +: 32] <= m_writedata;
            else if (m_address == 6'h20) begin
                ctrl    <= m_writedata[3:0];
                final_p <= block_fn(init_p, int'(m_writedata[3:0]));
            end
        end else if (ctrl != 4'd0 && (!core_jitter || $urandom_range(0, 2) != 0)) begin
            ctrl <= ctrl - 4'd1;
        end
        if (m_read) begin
            if (m_address == 6'h20) m_readdata <= {28'd0, ctrl};
            else if (m_address[5:4] == 2'b01) m_readdata <= final_p[int'(m_address[3:0])*32 +: 32];
            else m_readdata <= init_p[int'(m_address[3:0])*32 +: 32];
        end
    end

    // Stream/bus monitor sampled mid-cycle
    always @(negedge clock) begin
        if (!reset) begin
            check("rd_wr_exclusive", {63'd0, m_read & m_write}, 64'd0);
            if (ks_valid_o) check("no_read_while_out", {63'd0, m_read}, 64'd0);
            if (prev_hold) begin
                check("hold_valid", {63'd0, ks_valid_o}, 64'd1);
                check("hold_data", {32'd0, ks_data_o}, {32'd0, prev_data});
                check("hold_last", {63'd0, ks_last_o}, {63'd0, prev_last});
            end
            prev_hold = ks_valid_o && !ks_ready_i;
            prev_data = ks_data_o;
            prev_last = ks_last_o;
            if (ks_valid_o && ks_ready_i) begin
                got_q.push_back(ks_data_o);
                last_q.push_back(ks_last_o);
            end
            if (done_o)  done_cnt++;
            if (m_write) wr_cnt++;
            if (m_read)  rd_cnt++;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Consumer: ready high, or random 0-5 idle cycles between acceptances
    initial begin
        ks_ready_i = 1'b1;
        forever begin
            @(posedge clock); #1;
            if (bp_mode) begin
                if (gap > 0) begin ks_ready_i = 1'b0; gap--; end
                else begin ks_ready_i = 1'b1; gap = $urandom_range(0, 5); end
            end else begin
                ks_ready_i = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic start_run(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                             input int nb);
        key_i = k; nonce_i = n; counter_i = c; num_blocks_i = BLK_W'(nb);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        key_i = {8{$urandom}}; nonce_i = {3{$urandom}}; counter_i = $urandom;
        num_blocks_i = BLK_W'($urandom_range(1, 9));
    endtask

    task automatic wait_done(input string tag, input int maxc);
        int d0, i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < maxc) begin tick(1); i++; end
        check(tag, {63'd0, done_cnt != d0}, 64'd1);
        tick(2);
    endtask

    task automatic build_exp(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                             input int nb);
        logic [511:0] b;
        exp_q.delete();
        for (int i = 0; i < nb; i++) begin
            b = ref_block(k, n, c + 32'(i));
            for (int w = 0; w < 16; w++) exp_q.push_back(b[w*32 +: 32]);
        end
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", tag, i), {32'd0, got_q[i]}, {32'd0, exp_q[i]});
            check($sformatf("%s_last%0d", tag, i), {63'd0, last_q[i]},
                  {63'd0, i == exp_q.size() - 1});
        end
    endtask

    task automatic clear_stream();
        got_q.delete();
        last_q.delete();
    endtask

    logic [255:0] rfc_key, rkey;
    logic [95:0]  rfc_nonce, rnonce;
    logic [31:0]  rctr;
    logic [31:0]  blk2 [16];
    int           d0, w0, r0, i;

    initial begin
        reset = 1'b1; start_i = 1'b0; key_i = 256'd0; nonce_i = 96'd0;
        counter_i = 32'd0; num_blocks_i = '0;
        for (int k = 0; k < 32; k++) rfc_key[8*k +: 8] = 8'(k);
        rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
        tick(3);
        check("reset_ctrl", {52'd0, busy_o, done_o, error_o, m_read, m_write, m_address,
                             ks_valid_o, ks_last_o}, 64'd0);
        check("reset_wdata", {32'd0, m_writedata}, 64'd0);
        check("reset_ksdata", {32'd0, ks_data_o}, 64'd0);
        reset = 1'b0;
        tick(1);

        // RFC 7539 2.3.2 single block
        clear_stream(); d0 = done_cnt; w0 = wr_cnt;
        start_run(rfc_key, rfc_nonce, 32'd1, 1);
        check("busy_after_start", {63'd0, busy_o}, 64'd1);
        wait_done("rfc1_done", 2000);
        check("rfc1_count", 64'(got_q.size()), 64'd16);
        for (int k = 0; k < 16 && k < got_q.size(); k++) begin
            check($sformatf("rfc1_w%0d", k), {32'd0, got_q[k]}, {32'd0, rfc[k]});
            check($sformatf("rfc1_last%0d", k), {63'd0, last_q[k]}, {63'd0, k == 15});
        end
        check("rfc1_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("rfc1_writes", 64'(wr_cnt - w0), 64'd17);
        check("rfc1_busy_end", {63'd0, busy_o}, 64'd0);

        // three blocks: only word 12 plus CONTROL rewritten between blocks
        clear_stream(); w0 = wr_cnt;
        start_run(rfc_key, rfc_nonce, 32'd1, 3);
        wait_done("rfc3_done", 4000);
        build_exp(rfc_key, rfc_nonce, 32'd1, 3);
        compare_stream("rfc3");
        check("rfc3_writes", 64'(wr_cnt - w0), 64'd21);
        for (int k = 0; k < 16; k++) blk2[k] = (got_q.size() > 16 + k) ? got_q[16 + k] : 32'd0;
        clear_stream();
        start_run(rfc_key, rfc_nonce, 32'd2, 1);
        wait_done("ctr2_done", 2000);
        check("ctr2_count", 64'(got_q.size()), 64'd16);
        for (int k = 0; k < 16 && k < got_q.size(); k++)
            check($sformatf("blk2_vs_single_w%0d", k), {32'd0, got_q[k]}, {32'd0, blk2[k]});

        // random key/nonce, backpressure, slow core, ignored start mid-run
        rkey = {8{$urandom}}; rnonce = {3{$urandom}}; rctr = $urandom & 32'h7fff_ffff;
        clear_stream(); d0 = done_cnt;
        bp_mode = 1'b1; core_jitter = 1'b1;
        start_run(rkey, rnonce, rctr, 2);
        tick(25);
        num_blocks_i = BLK_W'(5); key_i = ~rkey;
        start_i = 1'b1; tick(1); start_i = 1'b0;
        wait_done("bp_done", 6000);
        bp_mode = 1'b0; core_jitter = 1'b0;
        tick(2);
        build_exp(rkey, rnonce, rctr, 2);
        compare_stream("bp");
        check("bp_done_pulses", 64'(done_cnt - d0), 64'd1);

        // counter wrap
        clear_stream();
        start_run(rkey, rnonce, 32'hFFFF_FFFF, 2);
        wait_done("wrap_done", 4000);
`ifdef CHACHA_SEQ_WRAP_GUARD_EN
        build_exp(rkey, rnonce, 32'hFFFF_FFFF, 1);
        compare_stream("wrap_guard");
        check("wrap_error", {63'd0, error_o}, 64'd1);
`else
        build_exp(rkey, rnonce, 32'hFFFF_FFFF, 2);
        compare_stream("wrap_silent");
        check("wrap_error", {63'd0, error_o}, 64'd0);
`endif

        // zero-block start: done next cycle, no bus traffic, never busy
        d0 = done_cnt; w0 = wr_cnt; r0 = rd_cnt;
        start_run(rkey, rnonce, 32'd7, 0);
        check("nb0_done", {63'd0, done_o}, 64'd1);
        check("nb0_busy", {63'd0, busy_o}, 64'd0);
        tick(1);
        check("nb0_done_drop", {63'd0, done_o}, 64'd0);
        check("nb0_busy_after", {63'd0, busy_o}, 64'd0);
        check("nb0_error_cleared", {63'd0, error_o}, 64'd0);
        tick(3);
        check("nb0_no_bus", 64'((wr_cnt - w0) + (rd_cnt - r0)), 64'd0);
        check("nb0_done_pulses", 64'(done_cnt - d0), 64'd1);

        // reset while a result read is in flight
        start_run(rfc_key, rfc_nonce, 32'd1, 1);
        i = 0;
        while (!(m_read && m_address == 6'h10) && i < 500) begin tick(1); i++; end
        check("rst_found_read", {63'd0, m_read && m_address == 6'h10}, 64'd1);
        tick(1);
        d0 = done_cnt;
        reset = 1'b1;
        tick(1);
        check("rst_ctrl", {52'd0, busy_o, done_o, error_o, m_read, m_write, m_address,
                           ks_valid_o, ks_last_o}, 64'd0);
        check("rst_data", {m_writedata, ks_data_o}, 64'd0);
        reset = 1'b0;
        tick(2);
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        clear_stream();
        start_run(rfc_key, rfc_nonce, 32'd1, 1);
        wait_done("rst_rerun_done", 2000);
        check("rst_rerun_count", 64'(got_q.size()), 64'd16);
        for (int k = 0; k < 16 && k < got_q.size(); k++)
            check($sformatf("rst_rerun_w%0d", k), {32'd0, got_q[k]}, {32'd0, rfc[k]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
